// File: rtl/id_pkg.sv
// id_pkg: opcode and ALU encodings plus the decoded-control struct shared
// by the decoder and the ID/EX pipeline stage.
package id_pkg;

    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BLT  = 4'b1001;
    localparam logic [3:0] OP_BLE  = 4'b1010;
    localparam logic [3:0] OP_JAL  = 4'b1100;
    localparam logic [3:0] OP_JLR  = 4'b1101;
    localparam logic [3:0] OP_JRI  = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_ADDV  = 3'b001;
    localparam logic [2:0] ALU_ADDC  = 3'b010;
    localparam logic [2:0] ALU_ADDV2 = 3'b011;
    localparam logic [2:0] ALU_NAND  = 3'b100;
    localparam logic [2:0] ALU_NANDV = 3'b101;
    localparam logic [2:0] ALU_CMP   = 3'b110;

    // rd is 0 for instructions that do not write a register.
    typedef struct packed {
        logic [2:0] alu;
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic [2:0] rd;
        logic       src_a_used;
        logic       src_b_used;
        logic       illegal;
    } id_ctrl_t;

endpackage

// File: rtl/id_decode.sv
// id_decode: purely combinational instruction decoder, ir -> id_ctrl_t.
// Fields: op=IR[15:12], RA=IR[11:9], RB=IR[8:6], RC=IR[5:3], func=IR[2:0].
module id_decode
    import id_pkg::*;
(
    input  logic [15:0] ir,
    output id_ctrl_t    ctrl
);

    logic [3:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rc;
    logic [2:0] func;

    assign op   = ir[15:12];
    assign ra   = ir[11:9];
    assign rb   = ir[8:6];
    assign rc   = ir[5:3];
    assign func = ir[2:0];

    // Opcode/func decode; all-zero word is a legal NOP, illegal encodings leave every enable low.
    always_comb begin
        ctrl = '0;
        if (ir != '0) begin
            case (op)
                OP_ADI: begin
                    ctrl.reg_wr     = 1'b1;
                    ctrl.rd         = rb;
                    ctrl.src_a_used = 1'b1;
                end
                OP_ADD: begin
                    case (func)
                        3'b011:                 ctrl.alu = ALU_ADDC;
                        3'b100, 3'b101, 3'b110: ctrl.alu = ALU_ADDV;
                        3'b111:                 ctrl.alu = ALU_ADDV2;
                        default:                ctrl.alu = ALU_ADD;
                    endcase
                    ctrl.reg_wr     = 1'b1;
                    ctrl.rd         = rc;
                    ctrl.src_a_used = 1'b1;
                    ctrl.src_b_used = 1'b1;
                end
                OP_NAND: begin
                    case (func)
                        3'b000, 3'b001, 3'b010: ctrl.alu = ALU_NAND;
                        3'b100, 3'b101, 3'b110: ctrl.alu = ALU_NANDV;
                        default:                ctrl.illegal = 1'b1;
                    endcase
                    if (!ctrl.illegal) begin
                        ctrl.reg_wr     = 1'b1;
                        ctrl.rd         = rc;
                        ctrl.src_a_used = 1'b1;
                        ctrl.src_b_used = 1'b1;
                    end
                end
                OP_LW: begin
                    ctrl.reg_wr     = 1'b1;
                    ctrl.mem_rd     = 1'b1;
                    ctrl.rd         = ra;
                    ctrl.src_b_used = 1'b1;
                end
                OP_SW: begin
                    ctrl.mem_wr     = 1'b1;
                    ctrl.src_a_used = 1'b1;
                    ctrl.src_b_used = 1'b1;
                end
                OP_BEQ, OP_BLT, OP_BLE: begin
                    ctrl.alu        = ALU_CMP;
                    ctrl.src_a_used = 1'b1;
                    ctrl.src_b_used = 1'b1;
                end
                OP_JAL: begin
                    ctrl.reg_wr = 1'b1;
                    ctrl.rd     = ra;
                end
                OP_JLR: begin
                    ctrl.reg_wr     = 1'b1;
                    ctrl.rd         = ra;
                    ctrl.src_b_used = 1'b1;
                end
                OP_JRI: begin
                    ctrl.src_a_used = 1'b1;
                end
                default: ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with ID/EX register, valid/ready handshake,
// flush, load-use interlock (one bubble per hazard) and a saturating bubble
// counter. Optional macro ID_ILLEGAL_TRAP_EN adds ex_illegal and the sticky
// illegal_seen outputs.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_W-1:0]       pc_in,
    input  logic [PC_W-1:0]       pc2_in,
    input  logic [15:0]           ir_in,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  ex_valid,
    output logic [PC_W-1:0]       ex_pc,
    output logic [PC_W-1:0]       ex_pc2,
    output logic [15:0]           ex_ir,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic                  ex_reg_wr_en,
    output logic                  ex_mem_wr_en,
    output logic                  ex_mem_rd_en,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic [CNT_W-1:0]      bubble_cnt
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic                  ex_illegal,
    output logic                  illegal_seen
`endif
);

    id_ctrl_t dec;

    id_decode u_decode (
        .ir   (ir_in),
        .ctrl (dec)
    );

    logic                  ex_valid_q,     ex_valid_d;
    logic [PC_W-1:0]       ex_pc_q,        ex_pc_d;
    logic [PC_W-1:0]       ex_pc2_q,       ex_pc2_d;
    logic [15:0]           ex_ir_q,        ex_ir_d;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl_q,  ex_alu_ctrl_d;
    logic                  ex_reg_wr_q,    ex_reg_wr_d;
    logic                  ex_mem_wr_q,    ex_mem_wr_d;
    logic                  ex_mem_rd_q,    ex_mem_rd_d;
    logic [REG_ADDR_W-1:0] ex_rd_addr_q,   ex_rd_addr_d;
    logic [CNT_W-1:0]      bubble_cnt_q,   bubble_cnt_d;
`ifdef ID_ILLEGAL_TRAP_EN
    logic                  ex_illegal_q,   ex_illegal_d;
    logic                  illegal_seen_q, illegal_seen_d;
`endif

    logic advance;
    logic src_hit;
    logic load_use;
    logic accept;

    // Handshake and load-use interlock against the load sitting in ID/EX.
    always_comb begin
        advance  = !ex_valid_q || out_ready;
        src_hit  = !dec.illegal &&
                   ((dec.src_a_used && ex_rd_addr_q == REG_ADDR_W'(ir_in[11:9])) ||
                    (dec.src_b_used && ex_rd_addr_q == REG_ADDR_W'(ir_in[8:6])));
        load_use = in_valid && ex_valid_q && ex_mem_rd_q && src_hit;
        in_ready = rst_n && (flush || (advance && !load_use));
        accept   = !flush && in_valid && in_ready;
    end

    // ID/EX next state: flush > accept > bubble > hold; data fields hold on bubbles.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_pc2_d      = ex_pc2_q;
        ex_ir_d       = ex_ir_q;
        ex_alu_ctrl_d = ex_alu_ctrl_q;
        ex_reg_wr_d   = ex_reg_wr_q;
        ex_mem_wr_d   = ex_mem_wr_q;
        ex_mem_rd_d   = ex_mem_rd_q;
        ex_rd_addr_d  = ex_rd_addr_q;
        bubble_cnt_d  = bubble_cnt_q;
`ifdef ID_ILLEGAL_TRAP_EN
        ex_illegal_d   = ex_illegal_q;
        illegal_seen_d = illegal_seen_q;
`endif
        if (flush || (!accept && advance)) begin
            ex_valid_d = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
            ex_illegal_d = 1'b0;
`endif
        end else if (accept) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = pc_in;
            ex_pc2_d      = pc2_in;
            ex_ir_d       = ir_in;
            ex_alu_ctrl_d = ALU_CTRL_W'(dec.alu);
            ex_reg_wr_d   = dec.reg_wr;
            ex_mem_wr_d   = dec.mem_wr;
            ex_mem_rd_d   = dec.mem_rd;
            ex_rd_addr_d  = REG_ADDR_W'(dec.rd);
`ifdef ID_ILLEGAL_TRAP_EN
            ex_illegal_d   = dec.illegal;
            illegal_seen_d = illegal_seen_q || dec.illegal;
`endif
        end
        if (load_use && advance && !flush && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register and counters, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_pc2_q      <= '0;
            ex_ir_q       <= '0;
            ex_alu_ctrl_q <= '0;
            ex_reg_wr_q   <= 1'b0;
            ex_mem_wr_q   <= 1'b0;
            ex_mem_rd_q   <= 1'b0;
            ex_rd_addr_q  <= '0;
            bubble_cnt_q  <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
            ex_illegal_q   <= 1'b0;
            illegal_seen_q <= 1'b0;
`endif
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_pc2_q      <= ex_pc2_d;
            ex_ir_q       <= ex_ir_d;
            ex_alu_ctrl_q <= ex_alu_ctrl_d;
            ex_reg_wr_q   <= ex_reg_wr_d;
            ex_mem_wr_q   <= ex_mem_wr_d;
            ex_mem_rd_q   <= ex_mem_rd_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            bubble_cnt_q  <= bubble_cnt_d;
`ifdef ID_ILLEGAL_TRAP_EN
            ex_illegal_q   <= ex_illegal_d;
            illegal_seen_q <= illegal_seen_d;
`endif
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_pc2       = ex_pc2_q;
    assign ex_ir        = ex_ir_q;
    assign ex_alu_ctrl  = ex_alu_ctrl_q;
    assign ex_reg_wr_en = ex_reg_wr_q;
    assign ex_mem_wr_en = ex_mem_wr_q;
    assign ex_mem_rd_en = ex_mem_rd_q;
    assign ex_rd_addr   = ex_rd_addr_q;
    assign bubble_cnt   = bubble_cnt_q;
`ifdef ID_ILLEGAL_TRAP_EN
    assign ex_illegal   = ex_illegal_q;
    assign illegal_seen = illegal_seen_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: decode vector table plus hand-written hazard, flush and
// reset sequences; a scoreboard checks every instruction leaving ID/EX.
module tb_id_stage_pipe;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   pc_in;
    logic [15:0]   pc2_in;
    logic [15:0]   ir_in;
    logic          flush;
    logic          out_ready;
    logic          ex_valid;
    logic [15:0]   ex_pc;
    logic [15:0]   ex_pc2;
    logic [15:0]   ex_ir;
    logic [2:0]    ex_alu_ctrl;
    logic          ex_reg_wr_en;
    logic          ex_mem_wr_en;
    logic          ex_mem_rd_en;
    logic [2:0]    ex_rd_addr;
    logic [CW-1:0] bubble_cnt;
`ifdef ID_ILLEGAL_TRAP_EN
    logic          ex_illegal;
    logic          illegal_seen;
`endif

    always #5 clk = ~clk;

    id_stage_pipe #(
        .PC_W       (16),
        .ALU_CTRL_W (3),
        .REG_ADDR_W (3),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .pc2_in       (pc2_in),
        .ir_in        (ir_in),
        .flush        (flush),
        .out_ready    (out_ready),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_pc2       (ex_pc2),
        .ex_ir        (ex_ir),
        .ex_alu_ctrl  (ex_alu_ctrl),
        .ex_reg_wr_en (ex_reg_wr_en),
        .ex_mem_wr_en (ex_mem_wr_en),
        .ex_mem_rd_en (ex_mem_rd_en),
        .ex_rd_addr   (ex_rd_addr),
        .bubble_cnt   (bubble_cnt)
`ifdef ID_ILLEGAL_TRAP_EN
        ,
        .ex_illegal   (ex_illegal),
        .illegal_seen (illegal_seen)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [2:0]  alu;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [2:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  alu;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [2:0]  rd;
        logic        ill;
    } vec_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned exp_bub  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pc, input logic [15:0] ir, input logic [2:0] alu,
                                input logic rw, input logic mw, input logic mr,
                                input logic [2:0] rd, input logic ill);
        exp_t e;
        e.pc = pc; e.ir = ir; e.alu = alu; e.rw = rw; e.mw = mw; e.mr = mr; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    // Drive an instruction at the current negedge; push its expectation unless it is to be killed.
    task automatic send(input exp_t e, input bit push);
        in_valid = 1'b1;
        ir_in    = e.ir;
        pc_in    = e.pc;
        pc2_in   = e.pc + 16'd2;
        if (push) sb.push_back(e);
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    // Scoreboard: an instruction leaves ID/EX on the edge where ex_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && ex_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ex: ir 0x%0h left EX with nothing expected", ex_ir);
                end else begin
                    e = sb.pop_front();
                    chk("ex_ir",     ex_ir,        e.ir);
                    chk("ex_pc",     ex_pc,        e.pc);
                    chk("ex_pc2",    ex_pc2,       e.pc + 16'd2);
                    chk("ex_alu",    ex_alu_ctrl,  e.alu);
                    chk("ex_reg_wr", ex_reg_wr_en, e.rw);
                    chk("ex_mem_wr", ex_mem_wr_en, e.mw);
                    chk("ex_mem_rd", ex_mem_rd_en, e.mr);
                    chk("ex_rd",     ex_rd_addr,   e.rd);
`ifdef ID_ILLEGAL_TRAP_EN
                    chk("ex_illegal", ex_illegal, e.ill);
`endif
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_valid"},  ex_valid,     0);
        chk({tag, "_ex_pc"},     ex_pc,        0);
        chk({tag, "_ex_pc2"},    ex_pc2,       0);
        chk({tag, "_ex_ir"},     ex_ir,        0);
        chk({tag, "_ex_alu"},    ex_alu_ctrl,  0);
        chk({tag, "_ex_reg_wr"}, ex_reg_wr_en, 0);
        chk({tag, "_ex_mem_wr"}, ex_mem_wr_en, 0);
        chk({tag, "_ex_mem_rd"}, ex_mem_rd_en, 0);
        chk({tag, "_ex_rd"},     ex_rd_addr,   0);
        chk({tag, "_bubble"},    bubble_cnt,   0);
        chk({tag, "_in_ready"},  in_ready,     0);
`ifdef ID_ILLEGAL_TRAP_EN
        chk({tag, "_ex_illegal"},   ex_illegal,   0);
        chk({tag, "_illegal_seen"}, illegal_seen, 0);
`endif
    endtask

    // LW r5 then ADD reading r5; out_ready held low for 'stall' cycles after the LW lands in EX.
    task automatic hazard_seq(input int stall);
        @(negedge clk);
        out_ready = 1'b1;
        send(mk(16'h0200, 16'h4A80, 3'b000, 1, 0, 1, 3'd5, 0), 1);
        #1 chk("lw_in_ready", in_ready, 1);
        @(negedge clk);
        send(mk(16'h0202, 16'h1A00, 3'b000, 1, 0, 0, 3'd0, 0), 1);
        out_ready = (stall == 0);
        #1 chk("hazard_in_ready", in_ready, 0);
        for (int k = 1; k < stall; k++) begin
            @(negedge clk);
            #1;
            chk("stall_ex_valid", ex_valid,   1);
            chk("stall_ex_ir",    ex_ir,      16'h4A80);
            chk("stall_in_ready", in_ready,   0);
            chk("stall_bubble",   bubble_cnt, exp_bub);
        end
        if (stall > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1 chk("release_in_ready", in_ready, 0);
        end
        exp_bub = sat_inc(exp_bub);
        @(negedge clk);
        #1;
        chk("bubble_ex_valid", ex_valid,   0);
        chk("bubble_cnt",      bubble_cnt, exp_bub);
        chk("bubble_in_ready", in_ready,   1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("add_ex_valid", ex_valid,   1);
        chk("add_ex_ir",    ex_ir,      16'h1A00);
        chk("add_bubble",   bubble_cnt, exp_bub);
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{16'h129B, 3'b010, 1, 0, 0, 3'd3, 0};
        tbl[1]  = '{16'h0A80, 3'b000, 1, 0, 0, 3'd2, 0};
        tbl[2]  = '{16'h14E4, 3'b001, 1, 0, 0, 3'd4, 0};
        tbl[3]  = '{16'h103F, 3'b011, 1, 0, 0, 3'd7, 0};
        tbl[4]  = '{16'h1008, 3'b000, 1, 0, 0, 3'd1, 0};
        tbl[5]  = '{16'h2271, 3'b100, 1, 0, 0, 3'd6, 0};
        tbl[6]  = '{16'h2016, 3'b101, 1, 0, 0, 3'd2, 0};
        tbl[7]  = '{16'h2003, 3'b000, 0, 0, 0, 3'd0, 1};
        tbl[8]  = '{16'h4A80, 3'b000, 1, 0, 1, 3'd5, 0};
        tbl[9]  = '{16'h5A80, 3'b000, 0, 1, 0, 3'd0, 0};
        tbl[10] = '{16'h8A80, 3'b110, 0, 0, 0, 3'd0, 0};
        tbl[11] = '{16'hC200, 3'b000, 1, 0, 0, 3'd1, 0};
        tbl[12] = '{16'hD400, 3'b000, 1, 0, 0, 3'd2, 0};
        tbl[13] = '{16'hF600, 3'b000, 0, 0, 0, 3'd0, 0};
        tbl[14] = '{16'h0000, 3'b000, 0, 0, 0, 3'd0, 0};
        tbl[15] = '{16'h3000, 3'b000, 0, 0, 0, 3'd0, 1};
        tbl[16] = '{16'h7000, 3'b000, 0, 0, 0, 3'd0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        pc_in     = '0;
        pc2_in    = '0;
        ir_in     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single load-use hazard with EX always ready.
        hazard_seq(0);

        // Flush while an instruction is arriving and ID/EX is occupied.
        @(negedge clk);
        send(mk(16'h0300, 16'h129B, 3'b010, 1, 0, 0, 3'd3, 0), 1);
        @(negedge clk);
        send(mk(16'h0302, 16'h14E4, 3'b001, 1, 0, 0, 3'd4, 0), 0);
        flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 1);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1 chk("flush_ex_valid", ex_valid, 0);
        @(negedge clk);
        #1 chk("flush_idle_ex_valid", ex_valid, 0);

        // Asynchronous reset while ID/EX holds a valid instruction and the counter is non-zero.
        @(negedge clk);
        send(mk(16'h0400, 16'h129B, 3'b010, 1, 0, 0, 3'd3, 0), 1);
        @(posedge clk);
        #2;
        chk("pre_reset_ex_valid", ex_valid,   1);
        chk("pre_reset_bubble",   bubble_cnt, exp_bub);
        rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        sb.delete();
        exp_bub = 0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Hazard with EX stalled for 3 cycles, then enough hazards to saturate the counter.
        hazard_seq(3);
        hazard_seq(0);
        hazard_seq(0);
        hazard_seq(0);
        chk("bubble_saturated", bubble_cnt, (1 << CW) - 1);

        // Decode table: each vector issued alone, followed by an idle cycle.
        foreach (tbl[i]) begin
            @(negedge clk);
            send(mk(16'h1000 + 16'(i * 4), tbl[i].ir, tbl[i].alu, tbl[i].rw, tbl[i].mw,
                    tbl[i].mr, tbl[i].rd, tbl[i].ill), 1);
            #1 chk("tbl_in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("tbl_ex_valid", ex_valid, 1);
            @(negedge clk);
            #1 chk("tbl_idle_ex_valid", ex_valid, 0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
`ifdef ID_ILLEGAL_TRAP_EN
        chk("illegal_seen_sticky", illegal_seen, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the combinational instruction decoder.
- Decodes a 16-bit instruction into ALU and write-enable controls, and registers the result into the ID/EX pipeline register.
- Adds valid/ready flow control, a flush input, load-use hazard interlock with bubble injection, and a saturating bubble counter.
- Sits between the IF/ID register and the EX stage.

Parameters:
- PC_W, 16, width of pc/pc2 fields carried through the stage.
- ALU_CTRL_W, 3, width of the ALU control code; must be 3 or more.
- REG_ADDR_W, 3, register address width; fields sit at IR[11:9]=RA, IR[8:6]=RB, IR[5:3]=RC.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc_in  in  PC_W  instruction PC.
- pc2_in  in  PC_W  PC+2.
- ir_in  in  16  instruction word.
- flush  in  1  kill the instruction being accepted and empty ID/EX.
- out_ready  in  1  EX can take ID/EX contents.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_pc, ex_pc2  out  PC_W  registered PCs.
- ex_ir  out  16  registered instruction word.
- ex_alu_ctrl  out  ALU_CTRL_W  registered ALU code.
- ex_reg_wr_en, ex_mem_wr_en, ex_mem_rd_en  out  1  registered enables.
- ex_rd_addr  out  REG_ADDR_W  destination register.
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating.

Behaviour:
- Reset (rst_n=0, async): every ex_* output = 0, bubble_cnt = 0. in_ready is combinational and = 0 while rst_n=0.
- Decode (combinational, op=IR[15:12]). ALU codes: 000 add, 001 add-variant, 010 add-carry, 011 add-variant2, 100 nand, 101 nand-variant, 110 compare.
  - 0000 ADI: alu 000, reg_wr, rd=RB, srcs RA.
  - 0001 ADD family, by func[2:0]: 000/001/010 → alu 000; 011 → 010; 100/101/110 → 001; 111 → 011. reg_wr, rd=RC, srcs RA,RB.
  - 0010 NAND family: 000/001/010 → alu 100; 100/101/110 → alu 101; 011/111 illegal. reg_wr, rd=RC, srcs RA,RB.
  - 0100 LW: alu 000, reg_wr, mem_rd, rd=RA, src RB.
  - 0101 SW: alu 000, mem_wr, srcs RA,RB.
  - 1000/1001/1010 branches: alu 110, no writes, srcs RA,RB.
  - 1100 JAL: reg_wr, rd=RA, no srcs.
  - 1101 JLR: reg_wr, rd=RA, src RB.
  - 1111 JRI: no writes, src RA.
  - ir_in=0x0000 is NOP: all enables 0, alu 000, still propagated as valid.
  - Any other opcode/func is illegal: all enables 0, alu 000.
- advance = !ex_valid | out_ready.
- load_use = in_valid & ex_valid & ex_mem_rd_en & (ex_rd_addr matches a used source of ir_in).
- in_ready = advance & !load_use, or 1 when flush=1.
- Each rising edge, in priority order:
  - flush: ex_valid←0, input consumed and dropped.
  - else in_valid & in_ready: load decoded fields, ex_valid←1.
  - else advance: ex_valid←0 (bubble).
  - else hold all ex_*.
- Latency: exactly 1 cycle from acceptance to ex_valid.
- Load-use: exactly one bubble per hazard. If out_ready=0, the load stays in EX and the decode stays stalled with no extra count.
- bubble_cnt increments on edges where load_use & advance & !flush, and saturates at 2^CNT_W−1.
- ex_* data fields hold their last value when ex_valid=0. Consumers gate on ex_valid.

Optional Feature:
- ID_ILLEGAL_TRAP_EN defined:
  - Adds output ex_illegal (1 bit, reset 0), registered alongside ex_valid.
  - Set for illegal encodings; the instruction propagates with all enables 0.
  - A second output, illegal_seen, is a sticky bit cleared only by reset.
- Undefined: neither port exists and illegal encodings are silent NOPs.

Decomposition:
- Package id_pkg holds:
  - opcode localparams (OP_ADI … OP_JRI);
  - ALU code localparams (ALU_ADD, ALU_ADDC, ALU_NAND, ALU_CMP, …);
  - a decoded-control struct: alu, reg_wr, mem_wr, mem_rd, rd, src_a_used, src_b_used, illegal.
- Sub-module id_decode: purely combinational ir → control struct. It is reused by the hazard unit.
- id_stage_pipe holds the register, handshake, interlock and counter.

Test Plan:
- Reset mid-stream: assert rst_n=0 while ex_valid=1 → all ex_* and bubble_cnt are 0 immediately, without waiting for a clock edge.
- ADD func 011, ir=0x129B → one cycle later ex_alu_ctrl=010, ex_reg_wr_en=1, ex_rd_addr=3, ex_valid=1.
- LW ir=0x4A80 (rd=5), then ADD ir=0x1A00 reading RA=5 → one bubble (ex_valid=0 for one cycle), bubble_cnt=1, ADD appears in EX the following cycle.
- Same LW→ADD sequence with out_ready=0 for 3 cycles → LW held, in_ready=0, bubble_cnt still 1 after release.
- flush=1 with in_valid=1 and ex_valid=1 → next cycle ex_valid=0 and the flushed instruction never appears.
- Illegal opcode 0x3000 with ID_ILLEGAL_TRAP_EN defined → ex_illegal=1, all enables 0, illegal_seen=1 sticky. Without the macro → plain NOP behaviour.
